stopwatch_ctrl: RTL and testbench

- Run/pause/lap/clear controller wrapped around a 2-digit decimal count (00-99).
- Divides the system clock to a count tick and sequences the count from single-cycle button pulses, which come from the board debouncers.
- Freezes the displayed value on lap.
- Drives the ones/tens digits consumed by the 7-segment display path.

---
 rtl/stopwatch_pkg.sv | 21 ++
 rtl/stopwatch_if.sv | 28 ++
 rtl/stopwatch_bcd2_counter.sv | 38 +++
 rtl/stopwatch_ctrl.sv | 76 +++++++
 tb/tb_stopwatch_ctrl.sv | 169 ++++++++++++++++
 5 files changed

// File: rtl/stopwatch_pkg.sv
// stopwatch_pkg: shared types and constants for the stopwatch controller
//   state_t   : controller state encoding (IDLE, RUN, PAUSE, LAP)
//   bcd2_t    : two packed BCD digits {tens, ones}
//   DIGIT_MAX : highest value a BCD digit reaches before it rolls over
package stopwatch_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        LAP   = 2'd3
    } state_t;

    localparam logic [3:0] DIGIT_MAX = 4'd9;

    typedef struct packed {
        logic [3:0] tens;
        logic [3:0] ones;
    } bcd2_t;

endpackage

// File: rtl/stopwatch_if.sv
// stopwatch_if: button pulses in, display digits and status out
//   start_stop, clear, lap : single-cycle button pulses
//   ones, tens             : displayed BCD digits
//   running, lap_active    : status flags
//   wrap                   : one-cycle pulse when the count rolls 99 -> 00
//   master = button/display side, slave = controller
interface stopwatch_if;

    logic       start_stop;
    logic       clear;
    logic       lap;
    logic [3:0] ones;
    logic [3:0] tens;
    logic       running;
    logic       lap_active;
    logic       wrap;

    modport master (
        output start_stop, clear, lap,
        input  ones, tens, running, lap_active, wrap
    );

    modport slave (
        input  start_stop, clear, lap,
        output ones, tens, running, lap_active, wrap
    );

endinterface

// File: rtl/stopwatch_bcd2_counter.sv
// bcd2_counter: reusable 00-99 counter holding each digit as its own BCD nibble
//   clk, reset : clock and synchronous active-high reset
//   clr        : synchronous clear to 00, wins over en
//   en         : advance by one
//   value      : current {tens, ones}
//   wrap       : registered pulse aligned with the 00 that follows 99
module bcd2_counter
    import stopwatch_pkg::*;
(
    input  logic  clk,
    input  logic  reset,
    input  logic  clr,
    input  logic  en,
    output bcd2_t value,
    output logic  wrap
);

    logic ones_max;
    logic tens_max;

    assign ones_max = value.ones == DIGIT_MAX;
    assign tens_max = value.tens == DIGIT_MAX;

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            value <= '0;
            wrap  <= 1'b0;
        end else begin
            wrap <= en && ones_max && tens_max;
            if (en) begin
                value.ones <= ones_max ? 4'd0 : value.ones + 4'd1;
                if (ones_max)
                    value.tens <= tens_max ? 4'd0 : value.tens + 4'd1;
            end
        end
    end

endmodule

// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl: run/pause/lap/clear controller around a 00-99 BCD count
//   clk, reset : clock and synchronous active-high reset
//   bus        : button pulses in; digits, running, lap_active, wrap out
//   TICK_DIV   : clk cycles per count increment (>= 2)
module stopwatch_ctrl
    import stopwatch_pkg::*;
#(
    parameter int TICK_DIV = 50_000_000
)(
    input logic        clk,
    input logic        reset,
    stopwatch_if.slave bus
);

    localparam int PW = $clog2(TICK_DIV);

    localparam logic [1:0] S_IDLE  = IDLE;
    localparam logic [1:0] S_RUN   = RUN;
    localparam logic [1:0] S_PAUSE = PAUSE;
    localparam logic [1:0] S_LAP   = LAP;

    logic [1:0]    state;
    logic [1:0]    state_nx;
    logic [PW-1:0] pre;
    bcd2_t         count;
    bcd2_t         lap_q;
    logic          active;
    logic          tick;
    logic          cnt_wrap;

    assign active = state == S_RUN || state == S_LAP;
    assign tick   = active && pre == PW'(TICK_DIV - 1);

    // start_stop always lands in PAUSE from a counting state and in RUN otherwise
    always_comb begin
        state_nx = bus.clear                       ? S_IDLE :
                   bus.start_stop                  ? (active ? S_PAUSE : S_RUN) :
                   bus.lap && state == S_RUN       ? S_LAP :
                   bus.lap && state == S_LAP       ? S_RUN :
                                                     state;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
            pre   <= '0;
            lap_q <= '0;
        end else begin
            state <= state_nx;
            // prescaler freezes on the edge that leaves a counting state, but a tick still reloads it
            if (bus.clear || tick)
                pre <= '0;
            else if (active && !bus.start_stop)
                pre <= pre + 1'b1;
            // latch the pre-increment count; start_stop and clear outrank lap
            if (state == S_RUN && bus.lap && !bus.start_stop && !bus.clear)
                lap_q <= count;
        end
    end

    bcd2_counter u_count (
        .clk   (clk),
        .reset (reset),
        .clr   (bus.clear),
        .en    (tick),
        .value (count),
        .wrap  (cnt_wrap)
    );

    assign bus.ones       = state == S_LAP ? lap_q.ones : count.ones;
    assign bus.tens       = state == S_LAP ? lap_q.tens : count.tens;
    assign bus.running    = active;
    assign bus.lap_active = state == S_LAP;
    assign bus.wrap       = cnt_wrap;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// tb_stopwatch_ctrl: directed stimulus, per-cycle model comparison and literal checkpoints
module tb_stopwatch_ctrl;

    localparam int TD = 4;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   total = 0;
    int   bad = 0;

    stopwatch_if bus ();

    stopwatch_ctrl #(.TICK_DIV(TD)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // reference model: count as a plain integer 0..99, mode 0=idle 1=run 2=pause 3=lap
    int m_mode = 0;
    int m_cnt = 0;
    int m_latch = 0;
    int m_pre = 0;
    bit m_wrap = 1'b0;

    always @(posedge clk) begin
        bit counting;
        bit tick;
        counting = m_mode == 1 || m_mode == 3;
        if (reset) begin
            m_mode = 0; m_cnt = 0; m_latch = 0; m_pre = 0; m_wrap = 1'b0;
        end else if (bus.clear) begin
            m_mode = 0; m_cnt = 0; m_pre = 0; m_wrap = 1'b0;
        end else begin
            tick = counting && m_pre == TD - 1;
            m_wrap = tick && m_cnt == 99;
            if (m_mode == 1 && bus.lap && !bus.start_stop)
                m_latch = m_cnt;
            if (tick) begin
                m_cnt = (m_cnt + 1) % 100;
                m_pre = 0;
            end else if (counting && !bus.start_stop) begin
                m_pre = m_pre + 1;
            end
            if (bus.start_stop)
                m_mode = counting ? 2 : 1;
            else if (bus.lap && m_mode == 1)
                m_mode = 3;
            else if (bus.lap && m_mode == 3)
                m_mode = 1;
        end
    end

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    initial begin
        int shown;
        @(posedge clk);
        forever begin
            @(negedge clk);
            shown = m_mode == 3 ? m_latch : m_cnt;
            check("model_ones", int'(bus.ones), shown % 10);
            check("model_tens", int'(bus.tens), shown / 10);
            check("model_running", int'(bus.running), int'(m_mode == 1 || m_mode == 3));
            check("model_lap_active", int'(bus.lap_active), int'(m_mode == 3));
            check("model_wrap", int'(bus.wrap), int'(m_wrap));
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse(input bit ss, input bit cl, input bit lp);
        bus.start_stop = ss;
        bus.clear = cl;
        bus.lap = lp;
        @(negedge clk);
        bus.start_stop = 1'b0;
        bus.clear = 1'b0;
        bus.lap = 1'b0;
    endtask

    task automatic lit(input string name, input int t, input int o, input int run, input int la, input int w);
        check({name, "_disp"}, int'(bus.tens) * 10 + int'(bus.ones), t * 10 + o);
        check({name, "_running"}, int'(bus.running), run);
        check({name, "_lap_active"}, int'(bus.lap_active), la);
        check({name, "_wrap"}, int'(bus.wrap), w);
    endtask

    initial begin
        bus.start_stop = 1'b1;
        bus.clear = 1'b0;
        bus.lap = 1'b0;
        step(2);
        lit("reset", 0, 0, 0, 0, 0);
        reset = 1'b0;
        bus.start_stop = 1'b0;
        step(20);
        lit("idle_hold", 0, 0, 0, 0, 0);
        pulse(1, 0, 0);
        lit("start", 0, 0, 1, 0, 0);
        step(3);
        lit("pre_first", 0, 0, 1, 0, 0);
        step(1);
        lit("first", 0, 1, 1, 0, 0);
        step(4);
        lit("second", 0, 2, 1, 0, 0);
        step(32);
        lit("ten", 1, 0, 1, 0, 0);
        step(356);
        lit("at99", 9, 9, 1, 0, 0);
        step(4);
        lit("wrap", 0, 0, 1, 0, 1);
        step(1);
        lit("wrap_gone", 0, 0, 1, 0, 0);
        step(3);
        lit("after_wrap", 0, 1, 1, 0, 0);
        step(16);
        lit("five", 0, 5, 1, 0, 0);
        pulse(0, 0, 1);
        lit("lap_on", 0, 5, 1, 1, 0);
        step(27);
        lit("lap_hold", 0, 5, 1, 1, 0);
        pulse(0, 0, 1);
        lit("lap_off", 1, 2, 1, 0, 0);
        pulse(0, 1, 0);
        lit("clear", 0, 0, 0, 0, 0);
        pulse(1, 0, 0);
        step(30);
        lit("seven", 0, 7, 1, 0, 0);
        pulse(1, 0, 0);
        lit("pause", 0, 7, 0, 0, 0);
        pulse(0, 0, 1);
        step(29);
        lit("pause_hold", 0, 7, 0, 0, 0);
        pulse(1, 0, 0);
        lit("resume", 0, 7, 1, 0, 0);
        step(1);
        lit("resume_p1", 0, 7, 1, 0, 0);
        step(1);
        lit("resume_p2", 0, 8, 1, 0, 0);
        step(100);
        lit("thirty3", 3, 3, 1, 0, 0);
        pulse(1, 1, 0);
        lit("clear_ss", 0, 0, 0, 0, 0);
        step(5);
        lit("clear_ss_idle", 0, 0, 0, 0, 0);
        pulse(1, 0, 0);
        step(399);
        lit("pre_clear99", 9, 9, 1, 0, 0);
        pulse(0, 1, 0);
        lit("tick_clear", 0, 0, 0, 0, 0);
        step(1);
        lit("tick_clear_nw", 0, 0, 0, 0, 0);
        step(4);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
